dynamic_obst_ctl: RTL
=====================

DYNAMIC_OBST_CTL -- requirements
Module: dynamic_obst_ctl

Interface
REQ-001 The block SHALL have parameter X_MIN, default 100: left limit of the obstacle column, in pixels.
REQ-002 The block SHALL have parameter X_MAX, default 700: exclusive right limit of the obstacle column, in pixels.
REQ-003 The block SHALL have parameter WIDTH, default 50: obstacle width, which must match the downstream obstacle drawer.
REQ-004 The block SHALL have parameter Y_POS, default 150: constant top y of the obstacle column.
REQ-005 The block SHALL have parameter STEP, default 4: pixels moved per step tick.
REQ-006 The block SHALL have parameter FRAME_DIV, default 1: number of frames per step tick.
REQ-007 The block SHALL have parameter HOLD_FRAMES, default 30: number of step ticks paused at each edge.
REQ-008 The block SHALL have port pclk  input  1  pixel clock; the only clock.
REQ-009 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-010 The block SHALL have port enable  input  1  high = motion allowed.
REQ-011 The block SHALL have port vblank_in  input  1  vertical blank from the timing chain.
REQ-012 The block SHALL have port x_pos  output  12  obstacle left x; registered.
REQ-013 The block SHALL have port y_pos  output  12  obstacle top y; registered.
REQ-014 The block SHALL have port dir  output  1  0 = moving right, 1 = moving left; registered.

Function
REQ-015 Frame tick SHALL be vblank_in AND NOT vblank_d, where vblank_d is vblank_in registered on pclk; exactly one tick per rising edge of vblank_in.
REQ-016 Step tick SHALL be a frame tick on which frame counter == FRAME_DIV-1; the frame counter then wraps to 0, otherwise it increments on each frame tick.
REQ-017 The frame counter SHALL advance only while enable=1.
REQ-018 The state machine SHALL have the states IDLE, MOVE_R, MOVE_L and HOLD.
REQ-019 IDLE: on enable=1 the block SHALL go to MOVE_R if dir=0, else to MOVE_L; x_pos SHALL be unchanged.
REQ-020 MOVE_R, on a step tick: if x_pos+STEP >= X_MAX-WIDTH, then x_pos SHALL become X_MAX-WIDTH (clamped), dir SHALL become 1, and the state SHALL become HOLD; otherwise x_pos SHALL become x_pos+STEP.
REQ-021 MOVE_L, on a step tick: if x_pos <= X_MIN+STEP, then x_pos SHALL become X_MIN, dir SHALL become 0, and the state SHALL become HOLD; otherwise x_pos SHALL become x_pos-STEP.
REQ-022 HOLD SHALL consume exactly HOLD_FRAMES step ticks with no x_pos change, then go to MOVE_R if dir=0, else MOVE_L; the next step tick after that SHALL move.
REQ-023 If HOLD_FRAMES=0, the edge step SHALL go directly to the opposite MOVE state.
REQ-024 The hold counter SHALL be cleared on HOLD entry.
REQ-025 In any state, enable=0 SHALL force IDLE at the next pclk edge; x_pos and dir SHALL be held.
REQ-026 Leaving HOLD through enable=0 SHALL discard the hold count; re-enable SHALL resume motion immediately in direction dir.
REQ-027 Latency: x_pos SHALL change at the first pclk edge that samples vblank_in=1 after 0; x_pos and y_pos SHALL be stable for the whole active video.
REQ-028 vblank_in held high for any number of cycles SHALL produce one tick only.
REQ-029 Arithmetic SHALL use 13 bits internally so that x_pos+STEP cannot overflow; x_pos SHALL never leave [X_MIN, X_MAX-WIDTH].
REQ-030 y_pos SHALL be constant Y_POS; the three-obstacle vertical spacing is applied downstream.
REQ-031 Parameter legality SHALL be X_MIN+WIDTH+STEP <= X_MAX, STEP >= 1 and FRAME_DIV >= 1; violation SHALL be flagged by a simulation-time check.

Reset
REQ-032 rst=1 SHALL immediately, without a clock edge, set x_pos=X_MIN, y_pos=Y_POS, dir=0, state=IDLE, and frame counter, hold counter and vblank_d to 0.
REQ-033 Reset asserted mid-operation, including in HOLD, SHALL abandon all motion; after release, motion SHALL restart from X_MIN moving right on the first step tick following enable=1.

Structure
REQ-034 A shared constants include SHALL hold the screen size (800x600), obstacle WIDTH/HEIGHT (50/50), OBST_SEPARATION (100) and the obstacle colour 12'hB59, used by this block and by the obstacle drawer.
REQ-035 The block SHALL use one sub-module, frame_tick_gen, containing the vblank edge detector and the FRAME_DIV divider, with output step_tick.

Verification
(Defaults except HOLD_FRAMES=2 and FRAME_DIV=1.)
REQ-036 Reset pulse with pclk stopped -> x_pos=100, y_pos=150 and dir=0 immediately.
REQ-037 enable=1 and three vblank rises -> x_pos=104, 108, 112, each one pclk after the rise.
REQ-038 x_pos=648 in MOVE_R and one tick -> x_pos=650 and dir=1; the next 2 ticks -> 650; the 3rd tick -> 646.
REQ-039 x_pos=102 in MOVE_L and one tick -> 100 and dir=0; after the hold -> 104.
REQ-040 enable=0 for 5 ticks at x=120 with dir=0 -> x stays 120; re-enable and one tick -> 124.
REQ-041 vblank_in held high for 1000 cycles, plus FRAME_DIV=3 with 6 rises -> one step only for the held-high vblank and exactly 2 steps for the 6 rises.

Source files
------------

// File: rtl/dynamic_obst_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dynamic_obst_ctl_pkg
//  Description : Shared screen/obstacle constants and the obstacle
//                controller state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package dynamic_obst_ctl_pkg;

    // Screen geometry
    localparam int c_screen_w = 800;
    localparam int c_screen_h = 600;

    // Obstacle geometry and look, shared with the obstacle drawer
    localparam int          c_obst_w          = 50;
    localparam int          c_obst_h          = 50;
    localparam int          c_obst_separation = 100;
    localparam logic [11:0] c_obst_colour     = 12'hB59;

    // Controller state encodings
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_move_r = 2'd1;
    localparam logic [1:0] c_st_move_l = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

endpackage : dynamic_obst_ctl_pkg
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Rising-edge detector on vblank_in plus a FRAME_DIV frame
//                divider; step_tick pulses for one pclk per FRAME_DIV frames.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tick_gen #(
    parameter int FRAME_DIV = 1
) (
    input  logic pclk,
    input  logic rst,
    input  logic enable,
    input  logic vblank_in,
    output logic step_tick
);

    localparam int             CW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0]  c_last = CW'(FRAME_DIV - 1);

    logic          r_vblank_d;
    logic [CW-1:0] r_frame_cnt;
    logic          w_frame_tick;
    logic          w_wrap;

    // One tick per rising edge, however long vblank stays high
    assign w_frame_tick = vblank_in & ~r_vblank_d;
    assign w_wrap       = (r_frame_cnt == c_last);
    assign step_tick    = w_frame_tick & enable & w_wrap;

    // Edge-detect delay and frame divider; divider only runs while enabled
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vblank_d  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vblank_d <= vblank_in;
            if (w_frame_tick && enable) begin
                r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + CW'(1);
            end
        end
    end

endmodule : frame_tick_gen
`default_nettype wire

// File: rtl/dynamic_obst_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : dynamic_obst_ctl
//  Description : Moves an obstacle column back and forth between X_MIN and
//                X_MAX-WIDTH, one STEP per step tick, pausing HOLD_FRAMES
//                step ticks at each edge.
//  Revision    : 1.0  initial release
// ============================================================================
module dynamic_obst_ctl
    import dynamic_obst_ctl_pkg::*;
#(
    parameter int X_MIN       = 100,
    parameter int X_MAX       = 700,
    parameter int WIDTH       = c_obst_w,
    parameter int Y_POS       = 150,
    parameter int STEP        = 4,
    parameter int FRAME_DIV   = 1,
    parameter int HOLD_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vblank_in,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        dir
);

    // Illegal parameter sets are caught at elaboration
    if ((X_MIN + WIDTH + STEP > X_MAX) || (STEP < 1) || (FRAME_DIV < 1) ||
        (X_MAX > c_screen_w) || (Y_POS + c_obst_h > c_screen_h)) begin : g_param_check
        $error("dynamic_obst_ctl: illegal parameters");
    end

    localparam int             HW          = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0]  c_hold_last = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam bit             c_has_hold  = (HOLD_FRAMES > 0);
    // 13-bit positions so x+STEP cannot wrap
    localparam logic [12:0]    c_x_right   = 13'(X_MAX - WIDTH);
    localparam logic [12:0]    c_x_lthresh = 13'(X_MIN + STEP);
    localparam logic [12:0]    c_step13    = 13'(STEP);

    logic          w_step_tick;
    logic [1:0]    r_state, w_state_nxt;
    logic [11:0]   r_x, w_x_nxt;
    logic [11:0]   r_y;
    logic          r_dir, w_dir_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_nxt;
    logic [12:0]   w_x_inc;
    logic [11:0]   w_x_dec;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_gen (
        .pclk      (pclk),
        .rst       (rst),
        .enable    (enable),
        .vblank_in (vblank_in),
        .step_tick (w_step_tick)
    );

    assign w_x_inc = {1'b0, r_x} + c_step13;
    // Only used when x > X_MIN+STEP, so no underflow
    assign w_x_dec = r_x - 12'(STEP);

    // State, position, direction and hold count registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_x        <= 12'(X_MIN);
            r_y        <= 12'(Y_POS);
            r_dir      <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= 12'(Y_POS);
            r_dir      <= w_dir_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state and motion decisions; disable wins over any step tick
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold_cnt;
        if (!enable) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_state_nxt = r_dir ? c_st_move_l : c_st_move_r;
                end
                c_st_move_r: begin
                    if (w_step_tick) begin
                        if (w_x_inc >= c_x_right) begin
                            w_x_nxt     = c_x_right[11:0];
                            w_dir_nxt   = 1'b1;
                            w_hold_nxt  = '0;
                            w_state_nxt = c_has_hold ? c_st_hold : c_st_move_l;
                        end else begin
                            w_x_nxt = w_x_inc[11:0];
                        end
                    end
                end
                c_st_move_l: begin
                    if (w_step_tick) begin
                        if ({1'b0, r_x} <= c_x_lthresh) begin
                            w_x_nxt     = 12'(X_MIN);
                            w_dir_nxt   = 1'b0;
                            w_hold_nxt  = '0;
                            w_state_nxt = c_has_hold ? c_st_hold : c_st_move_r;
                        end else begin
                            w_x_nxt = w_x_dec;
                        end
                    end
                end
                c_st_hold: begin
                    if (w_step_tick) begin
                        if (r_hold_cnt == c_hold_last) begin
                            w_state_nxt = r_dir ? c_st_move_l : c_st_move_r;
                        end else begin
                            w_hold_nxt = r_hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    assign x_pos = r_x;
    assign y_pos = r_y;
    assign dir   = r_dir;

endmodule : dynamic_obst_ctl
`default_nettype wire
